mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (CPU, I/O-DMA) arbiter in front of a single-port synchronous RAM.
// One transaction at a time through IDLE -> ACC -> WAIT -> DONE, round-robin on ties.
module mem_arbiter #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          Clock,
    input  logic          Reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,

    input  logic          io_req,
    input  logic          io_we,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic          io_gnt,
    output logic          io_done,
    output logic [DW-1:0] io_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_IO  = 1'b1;

    state_t        state;
    logic          owner;
    logic          last_served;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          pick_io;

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick_io = io_req;
        if (cpu_req && io_req) begin
            pick_io = (last_served == OWN_CPU);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            owner       <= OWN_CPU;
            last_served <= OWN_IO;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            cpu_rdata   <= '0;
            io_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || io_req) begin
                        state       <= ACC;
                        owner       <= pick_io;
                        last_served <= pick_io;
                        lat_we      <= pick_io ? io_we    : cpu_we;
                        lat_addr    <= pick_io ? io_addr  : cpu_addr;
                        lat_wdata   <= pick_io ? io_wdata : cpu_wdata;
                    end
                end
                ACC: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // RAM read data is valid now, one cycle after the ACC strobe.
                    state <= DONE;
                    if (!lat_we) begin
                        if (owner == OWN_IO) begin
                            io_rdata <= mem_rdata;
                        end else begin
                            cpu_rdata <= mem_rdata;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_en    = (state == ACC);
    assign mem_we    = (state == ACC) && lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    assign cpu_gnt  = (state == ACC)  && (owner == OWN_CPU);
    assign io_gnt   = (state == ACC)  && (owner == OWN_IO);
    assign cpu_done = (state == DONE) && (owner == OWN_CPU);
    assign io_done  = (state == DONE) && (owner == OWN_IO);

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a driver issues transactions and pushes expected
// completions; a negedge monitor pops and checks them whenever a done pulse appears.
module tb_mem_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt, cpu_done;
    logic [DW-1:0] cpu_rdata;
    logic          io_req = 1'b0, io_we = 1'b0;
    logic [AW-1:0] io_addr = '0;
    logic [DW-1:0] io_wdata = '0;
    logic          io_gnt, io_done;
    logic [DW-1:0] io_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          who;   // 0 = CPU, 1 = IO
        bit          rd;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    logic [31:0] sh_cpu = '0;
    logic [31:0] sh_io  = '0;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .Clock(Clock), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_gnt(io_gnt), .io_done(io_done), .io_rdata(io_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 Clock = ~Clock;

    // Synchronous RAM model with a preload port used only during initial reset.
    logic [31:0] ram [512];
    logic        init_ram = 1'b1;
    always @(posedge Clock) begin
        if (init_ram) ram[16] <= 32'hDEADBEEF;
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge Clock) begin
        if (cpu_done === 1'b1 || io_done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got cpu_done=%b io_done=%b expected none at %0t",
                         cpu_done, io_done, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cpu", {31'd0, cpu_done}, {31'd0, ~e.who});
                check("done_io",  {31'd0, io_done},  {31'd0,  e.who});
                if (e.rd) begin
                    if (e.who) sh_io = e.data;
                    else       sh_cpu = e.data;
                end
                check("cpu_rdata", cpu_rdata, sh_cpu);
                check("io_rdata",  io_rdata,  sh_io);
            end
        end
    end

    task automatic do_reset();
        @(posedge Clock); #1;
        Reset = 1'b1;
        cpu_req = 1'b0; io_req = 1'b0;
        sh_cpu = '0; sh_io = '0;
        @(posedge Clock); @(posedge Clock);
        @(negedge Clock);
        check("rst_busy",   {31'd0, busy},   32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_gnt",    {30'd0, cpu_gnt, io_gnt}, 32'd0);
        check("rst_cpu_rd", cpu_rdata, 32'd0);
        check("rst_io_rd",  io_rdata,  32'd0);
        check("rst_addr",   {23'd0, mem_addr}, 32'd0);
        check("rst_wdata",  mem_wdata, 32'd0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        init_ram = 1'b0;
    endtask

    // Single transaction from an idle arbiter; checks fixed latency and bus contents.
    task automatic do_txn(input bit who, input bit we, input logic [8:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd);
        exp_t e;
        @(posedge Clock); #1;
        if (who) begin io_req = 1; io_we = we; io_addr = a; io_wdata = wd; end
        else     begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
        e.who = who; e.rd = !we; e.data = exp_rd;
        sb.push_back(e);
        @(negedge Clock);
        check("idle_gnt", {30'd0, cpu_gnt, io_gnt}, 32'd0);
        @(negedge Clock);
        check("acc_gnt",    {30'd0, cpu_gnt, io_gnt}, who ? 32'd1 : 32'd2);
        check("acc_mem_en", {31'd0, mem_en}, 32'd1);
        check("acc_mem_we", {31'd0, mem_we}, {31'd0, we});
        check("acc_addr",   {23'd0, mem_addr}, {23'd0, a});
        if (we) check("acc_wdata", mem_wdata, wd);
        @(negedge Clock);
        check("wait_mem_en", {31'd0, mem_en}, 32'd0);
        check("wait_busy",   {31'd0, busy}, 32'd1);
        @(negedge Clock);
        check("done_latency", {30'd0, cpu_done, io_done}, who ? 32'd1 : 32'd2);
        @(posedge Clock); #1;
        cpu_req = 0; io_req = 0;
    endtask

    task automatic wait_done(input bit who, input string name);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge Clock);
            if ((who ? io_done : cpu_done) === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: got no done within 20 cycles expected done", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int ngnt;
        do_reset();

        // CPU read of preloaded word
        do_txn(0, 0, 9'h010, 32'h0, 32'hDEADBEEF);
        // IO write, then CPU reads it back
        do_txn(1, 1, 9'h1FF, 32'h12345678, 32'h0);
        do_txn(0, 0, 9'h1FF, 32'h0, 32'h12345678);
        // IO read of the same word
        do_txn(1, 0, 9'h1FF, 32'h0, 32'h12345678);

        // Withdrawal: request dropped and inputs changed during ACC
        @(posedge Clock); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        e.who = 0; e.rd = 1; e.data = 32'hDEADBEEF; sb.push_back(e);
        @(negedge Clock); @(negedge Clock);
        check("wd_acc_gnt", {31'd0, cpu_gnt}, 32'd1);
        cpu_req = 0; cpu_addr = 9'h055; cpu_we = 1; cpu_wdata = 32'hFFFF0000;
        @(negedge Clock);
        check("wd_addr_hold", {23'd0, mem_addr}, 32'h010);
        check("wd_we_hold",   {31'd0, mem_we}, 32'd0);
        @(negedge Clock);
        check("wd_done", {31'd0, cpu_done}, 32'd1);
        @(negedge Clock); @(negedge Clock);
        check("wd_idle", {31'd0, busy}, 32'd0);

        // Simultaneous continuous requests from reset: CPU, IO, CPU, IO
        do_reset();
        @(posedge Clock); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        io_req = 1;  io_we = 0;  io_addr = 9'h1FF;
        for (int k = 0; k < 4; k++) begin
            e.who = k[0]; e.rd = 1;
            e.data = k[0] ? 32'h12345678 : 32'hDEADBEEF;
            sb.push_back(e);
        end
        ngnt = 0;
        for (int n = 0; n < 16; n++) begin
            @(negedge Clock);
            ngnt += int'(cpu_gnt) + int'(io_gnt);
            if (n == 1 || n == 9)  check("rr_cpu_gnt", {30'd0, cpu_gnt, io_gnt}, 32'd2);
            if (n == 5 || n == 13) check("rr_io_gnt",  {30'd0, cpu_gnt, io_gnt}, 32'd1);
        end
        check("rr_gnt_count", ngnt, 32'd4);
        @(posedge Clock); #1;
        cpu_req = 0; io_req = 0;
        @(negedge Clock);
        check("rr_sb_empty", sb.size(), 32'd0);

        // Reset during WAIT of a CPU read aborts it
        @(posedge Clock); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h1FF;
        @(negedge Clock); @(negedge Clock);
        check("ab_acc_gnt", {31'd0, cpu_gnt}, 32'd1);
        @(negedge Clock);
        Reset = 1; cpu_req = 0;
        sh_cpu = '0; sh_io = '0;
        @(negedge Clock);
        check("ab_busy",   {31'd0, busy}, 32'd0);
        check("ab_done",   {31'd0, cpu_done}, 32'd0);
        check("ab_rdata",  cpu_rdata, 32'd0);
        check("ab_mem_en", {31'd0, mem_en}, 32'd0);
        @(posedge Clock); #1;
        Reset = 0;

        // Next tie goes to CPU
        @(posedge Clock); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        io_req = 1;  io_we = 0;  io_addr = 9'h1FF;
        e.who = 0; e.rd = 1; e.data = 32'hDEADBEEF; sb.push_back(e);
        e.who = 1; e.rd = 1; e.data = 32'h12345678; sb.push_back(e);
        @(negedge Clock); @(negedge Clock);
        check("tie_cpu_first", {30'd0, cpu_gnt, io_gnt}, 32'd2);
        wait_done(0, "tie_cpu_done");
        @(posedge Clock); #1;
        cpu_req = 0;
        wait_done(1, "tie_io_done");
        @(posedge Clock); #1;
        io_req = 0;
        repeat (4) @(negedge Clock);
        check("final_sb_empty", sb.size(), 32'd0);
        check("final_idle", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
